counter_bounce_multi: RTL and testbench
=======================================

Name: counter_bounce_multi

Overview:
- Parametrised successor of the fixed 3-bit up/down waterfall counter.
- Produces the LED-position index for the waterfall display.
- Runs on one clock with an advance strobe (tick) rather than a dedicated slow clock.
- Supports configurable width and bounds, four runtime-selectable count modes, synchronous load, freeze, and endpoint status/pulse outputs.

Parameters:
- W, 3, counter width in bits (2..16).
- LO, 0, lower bound of the count range (LO < HI, both < 2^W).
- HI, 7, upper bound of the count range.
- DWELL, 2, extra ticks held at each bounce endpoint (used only with COUNTER_DWELL_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- tick  in  1  advance strobe; the count steps only on cycles with tick=1.
- stop  in  1  freeze; while 1, ticks are ignored and state holds.
- load  in  1  synchronous load strobe.
- load_val  in  W  value for load; clamped into [LO,HI].
- mode  in  2  0=UP_WRAP, 1=DOWN_WRAP, 2=BOUNCE, 3=ONESHOT.
- counter  out  W  current count (registered).
- dir  out  1  1=counting up, 0=counting down (registered).
- at_lo  out  1  level, counter==LO (combinational from register).
- at_hi  out  1  level, counter==HI.
- turn  out  1  one-cycle pulse in the cycle after a wrap or reversal step.
- done  out  1  ONESHOT finished; sticky.

Behaviour:
- Reset (clr=1): counter=LO, dir=1, turn=0, done=0, dwell count=0.
- Priority, highest first: clr > load > stop > tick. With none active, all state holds and turn=0.
- Load:
  - counter=clamp(load_val), done=0, dwell=0, turn=0.
  - dir=0 if the clamped value is HI, else dir=1.
- Step (tick=1, stop=0); the next state is decided from the current counter, with no one-cycle lag:
  - UP_WRAP: HI→LO with turn=1; otherwise +1. dir=1.
  - DOWN_WRAP: LO→HI with turn=1; otherwise −1. dir=0.
  - BOUNCE:
    - If dir=1 and counter==HI: dir=0, counter=HI−1, turn=1. If dir=0 and counter==LO: dir=1, counter=LO+1, turn=1. Otherwise ±1 per dir.
    - Each endpoint appears exactly once per sweep. For LO=0, HI=7 the sequence is 0,1..7,6..0,1…
  - ONESHOT:
    - +1 until HI. On reaching HI, done=1 in the same update.
    - Further ticks hold at HI with done=1 and turn=0.
- Mode change:
  - Takes effect on the next step; counter is not reset.
  - Entering BOUNCE keeps the current dir. Entering ONESHOT from a position already at HI sets done on the next tick.
  - Leaving ONESHOT clears done on the next step.
- Arithmetic: W-bit unsigned. No result leaves [LO,HI]; no wrap through 0 or 2^W−1 unless those equal LO/HI.
- turn is registered: high for exactly one cycle after the qualifying step, low otherwise, including during stop.

Optional Feature:
- Macro: COUNTER_DWELL_EN.
- Defined:
  - BOUNCE mode only: on arriving at LO or HI, the counter holds for DWELL further ticks before reversing.
  - The internal dwell counter is cleared by clr, load and mode change.
  - turn pulses on the reversal step, not on arrival.
- Undefined: no dwell logic is built; DWELL is ignored; reversal is immediate as above.

Decomposition:
- Package counter_pkg holds:
  - the mode constants MODE_UP_WRAP=2'd0, MODE_DOWN_WRAP=2'd1, MODE_BOUNCE=2'd2, MODE_ONESHOT=2'd3;
  - a typedef for the 2-bit mode.
- Natural sub-module: counter_tick_div, a parametrised divider producing the one-cycle tick from clk (e.g. 1 Hz).
  - Instantiated beside this block by the top level, not inside it.
- The counter core itself stays a single module.

Test Plan:
- BOUNCE, W=3, LO=0, HI=7, tick every cycle → counter 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; turn pulses after the 7→6 and 0→1 steps only.
- UP_WRAP, LO=2, HI=5 → 2,3,4,5,2,3; turn=1 only after 5→2. DOWN_WRAP → 5,4,3,2,5; turn after 2→5.
- ONESHOT from LO=0 → 0..7, then done=1 with counter held at 7 for 5 more ticks. A load of 3 then gives counter=3, done=0.
- Count to 4 in BOUNCE, raise stop for 3 ticks → counter stays 4. Release → 5. Assert load=1 and stop=1 with load_val=9 (W=4, HI=7) → counter=7, dir=0.
- Count to 5, assert clr together with tick and load → next cycle counter=0, dir=1, done=0, turn=0.
- With COUNTER_DWELL_EN and DWELL=2, BOUNCE, LO=0, HI=3 → 0,1,2,3,3,3,2,1,0,0,0,1; without the macro → 0,1,2,3,2,1,0,1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared mode encoding for the waterfall position counter and its helpers.
package counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP_WRAP   = 2'd0;
    localparam mode_t MODE_DOWN_WRAP = 2'd1;
    localparam mode_t MODE_BOUNCE    = 2'd2;
    localparam mode_t MODE_ONESHOT   = 2'd3;

endpackage

// File: rtl/counter_bounce_multi_if.sv
// Control and status bundle of the waterfall counter; master drives strobes/mode,
// slave (the counter core) returns position and status.
interface counter_bounce_multi_if
    import counter_pkg::*;
#(
    parameter int W = 3
) ();

    logic         tick;
    logic         stop;
    logic         load;
    logic [W-1:0] load_val;
    mode_t        mode;
    logic [W-1:0] counter;
    logic         dir;
    logic         at_lo;
    logic         at_hi;
    logic         turn;
    logic         done;

    modport master (
        output tick, stop, load, load_val, mode,
        input  counter, dir, at_lo, at_hi, turn, done
    );

    modport slave (
        input  tick, stop, load, load_val, mode,
        output counter, dir, at_lo, at_hi, turn, done
    );

endinterface

// File: rtl/counter_bounce_multi_tick_div.sv
// Free-running divider giving a one-cycle advance strobe every DIV clocks;
// placed beside counter_bounce_multi to feed its tick input.
module counter_tick_div #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic clr,
    output logic tick_o
);

    localparam int CW = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/counter_bounce_multi.sv
// Parametrised waterfall position counter: wrap/bounce/oneshot modes, load, freeze.
// Optional endpoint dwell in BOUNCE mode is built when COUNTER_DWELL_EN is defined.
module counter_bounce_multi
    import counter_pkg::*;
#(
    parameter int W     = 3,
    parameter int LO    = 0,
    parameter int HI    = 7,
    parameter int DWELL = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    counter_bounce_multi_if.slave  bus
);

    generate
        if (W < 2 || W > 16 || LO < 0 || LO >= HI || HI >= (1 << W) || DWELL < 0) begin : g_bad_param
            $error("counter_bounce_multi: illegal W/LO/HI/DWELL combination");
        end
    endgenerate

    localparam logic [W-1:0] LO_V  = W'(LO);
    localparam logic [W-1:0] HI_V  = W'(HI);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         dir_q, dir_d;
    logic         turn_q, turn_d;
    logic         done_q, done_d;
    logic [W-1:0] load_c;
    logic         step;
    logic         at_end;
    logic         dwell_hold;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        if (v < LO_V) return LO_V;
        if (v > HI_V) return HI_V;
        return v;
    endfunction

    assign load_c = clamp(bus.load_val);
    assign step   = bus.tick && !bus.stop;
    // Facing outward at an endpoint: the next BOUNCE step reverses (or dwells).
    assign at_end = (dir_q && cnt_q == HI_V) || (!dir_q && cnt_q == LO_V);

`ifdef COUNTER_DWELL_EN
    localparam int DW_W = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_V = DW_W'(DWELL);

    logic [DW_W-1:0] dwell_q, dwell_d, dwell_cur;
    mode_t           mode_q, mode_d;

    // A mode differing from the one used on the last step restarts the dwell.
    assign dwell_cur  = (bus.mode != mode_q) ? '0 : dwell_q;
    assign dwell_hold = at_end && (dwell_cur != DWELL_V);

    always_comb begin
        dwell_d = dwell_q;
        mode_d  = mode_q;
        if (bus.load) begin
            dwell_d = '0;
            mode_d  = bus.mode;
        end else if (step) begin
            mode_d  = bus.mode;
            dwell_d = (bus.mode == MODE_BOUNCE && dwell_hold) ? dwell_cur + DW_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dwell_q <= '0;
            mode_q  <= bus.mode;
        end else begin
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end
`else
    assign dwell_hold = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        turn_d = 1'b0;
        done_d = done_q;
        if (bus.load) begin
            cnt_d  = load_c;
            dir_d  = (load_c != HI_V);
            done_d = 1'b0;
        end else if (step) begin
            done_d = 1'b0;
            case (bus.mode)
                MODE_UP_WRAP: begin
                    dir_d = 1'b1;
                    if (cnt_q == HI_V) begin
                        cnt_d  = LO_V;
                        turn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_V;
                    end
                end
                MODE_DOWN_WRAP: begin
                    dir_d = 1'b0;
                    if (cnt_q == LO_V) begin
                        cnt_d  = HI_V;
                        turn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE_V;
                    end
                end
                MODE_BOUNCE: begin
                    if (!at_end) begin
                        cnt_d = dir_q ? cnt_q + ONE_V : cnt_q - ONE_V;
                    end else if (!dwell_hold) begin
                        dir_d  = !dir_q;
                        cnt_d  = dir_q ? cnt_q - ONE_V : cnt_q + ONE_V;
                        turn_d = 1'b1;
                    end
                end
                MODE_ONESHOT: begin
                    dir_d = 1'b1;
                    if (cnt_q == HI_V) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + ONE_V;
                        done_d = (cnt_q + ONE_V == HI_V);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= LO_V;
            dir_q  <= 1'b1;
            turn_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            turn_q <= turn_d;
            done_q <= done_d;
        end
    end

    assign bus.counter = cnt_q;
    assign bus.dir     = dir_q;
    assign bus.turn    = turn_q;
    assign bus.done    = done_q;
    assign bus.at_lo   = (cnt_q == LO_V);
    assign bus.at_hi   = (cnt_q == HI_V);

endmodule

// File: tb/tb_counter_bounce_multi.sv
// Bench for counter_bounce_multi: directed scenarios plus a randomized run
// against a behavioural model, on three differently-parametrised instances.
module tb_counter_bounce_multi;
    import counter_pkg::*;

`ifdef COUNTER_DWELL_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    logic div_tick;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_bounce_multi_if #(.W(4)) ia ();
    counter_bounce_multi_if #(.W(3)) ib ();
    counter_bounce_multi_if #(.W(2)) ic ();

    counter_bounce_multi #(.W(4), .LO(0), .HI(7), .DWELL(2)) u_a (.clk(clk), .clr(clr), .bus(ia));
    counter_bounce_multi #(.W(3), .LO(2), .HI(5), .DWELL(2)) u_b (.clk(clk), .clr(clr), .bus(ib));
    counter_bounce_multi #(.W(2), .LO(0), .HI(3), .DWELL(2)) u_c (.clk(clk), .clr(clr), .bus(ic));
    counter_tick_div #(.DIV(4)) u_div (.clk(clk), .clr(clr), .tick_o(div_tick));

    typedef struct {
        int cnt;
        bit dir;
        bit turn;
        bit done;
        int spent;
        int lmode;
    } mdl_t;

    // Behavioural reference: position/direction rules applied with integer arithmetic.
    function automatic mdl_t mstep(mdl_t s, int lo, int hi, int dw, bit c, bit tk,
                                   bit sp, bit ld, int lv, int md);
        mdl_t n;
        int   hold;
        bit   outward;
        n      = s;
        n.turn = 0;
        hold   = (md == s.lmode) ? s.spent : 0;
        outward = (s.dir && s.cnt == hi) || (!s.dir && s.cnt == lo);
        if (c) begin
            n.cnt = lo; n.dir = 1; n.done = 0; n.spent = 0; n.lmode = md;
        end else if (ld) begin
            n.cnt = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            n.dir = (n.cnt != hi); n.done = 0; n.spent = 0; n.lmode = md;
        end else if (tk && !sp) begin
            n.done = 0; n.spent = 0; n.lmode = md;
            if (md == 0) begin
                n.dir = 1;
                n.cnt = (s.cnt == hi) ? lo : s.cnt + 1;
                n.turn = (s.cnt == hi);
            end else if (md == 1) begin
                n.dir = 0;
                n.cnt = (s.cnt == lo) ? hi : s.cnt - 1;
                n.turn = (s.cnt == lo);
            end else if (md == 2) begin
                if (!outward) n.cnt = s.dir ? s.cnt + 1 : s.cnt - 1;
                else if (DWELL_ON && hold < dw) n.spent = hold + 1;
                else begin
                    n.dir = !s.dir; n.cnt = s.dir ? s.cnt - 1 : s.cnt + 1; n.turn = 1;
                end
            end else begin
                n.dir = 1;
                if (s.cnt != hi) n.cnt = s.cnt + 1;
                n.done = (n.cnt == hi);
            end
        end
        return n;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ia.tick = 0; ia.stop = 0; ia.load = 0; ia.load_val = '0; ia.mode = MODE_UP_WRAP;
        ib.tick = 0; ib.stop = 0; ib.load = 0; ib.load_val = '0; ib.mode = MODE_UP_WRAP;
        ic.tick = 0; ic.stop = 0; ic.load = 0; ic.load_val = '0; ic.mode = MODE_UP_WRAP;
    endtask

    task automatic do_reset();
        idle_all();
        clr = 1;
        cyc();
        clr = 0;
    endtask

    task automatic test_reset();
        idle_all();
        ia.tick = 1; ia.load = 1; ia.load_val = 4'd5;
        clr = 1;
        cyc();
        clr = 0;
        idle_all();
        checks += 8;
        if (ia.counter !== 4'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d exp=0", ia.counter); end
        if (ia.dir !== 1'b1)     begin errors++; $display("FAIL reset_dir got=%0b exp=1", ia.dir); end
        if (ia.turn !== 1'b0)    begin errors++; $display("FAIL reset_turn got=%0b exp=0", ia.turn); end
        if (ia.done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%0b exp=0", ia.done); end
        if (ia.at_lo !== 1'b1)   begin errors++; $display("FAIL reset_at_lo got=%0b exp=1", ia.at_lo); end
        if (ia.at_hi !== 1'b0)   begin errors++; $display("FAIL reset_at_hi got=%0b exp=0", ia.at_hi); end
        if (ib.counter !== 3'd2) begin errors++; $display("FAIL reset_cnt_b got=%0d exp=2", ib.counter); end
        if (ic.counter !== 2'd0) begin errors++; $display("FAIL reset_cnt_c got=%0d exp=0", ic.counter); end
    endtask

    task automatic test_bounce();
        int exp_cnt[15]  = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        bit exp_turn[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        bit exp_dir;
        do_reset();
        ia.mode = MODE_BOUNCE; ia.tick = 1;
        for (int i = 0; i < 15; i++) begin
            cyc();
            exp_dir = !(i >= 7 && i <= 13);
            checks += 3;
            if (ia.counter !== exp_cnt[i]) begin errors++; $display("FAIL bounce_cnt[%0d] got=%0d exp=%0d", i, ia.counter, exp_cnt[i]); end
            if (ia.turn !== exp_turn[i])   begin errors++; $display("FAIL bounce_turn[%0d] got=%0b exp=%0b", i, ia.turn, exp_turn[i]); end
            if (ia.dir !== exp_dir)        begin errors++; $display("FAIL bounce_dir[%0d] got=%0b exp=%0b", i, ia.dir, exp_dir); end
        end
        ia.tick = 0;
    endtask

    task automatic test_wrap();
        int up_cnt[5]  = '{3, 4, 5, 2, 3};
        int dn_cnt[5]  = '{4, 3, 2, 5, 4};
        bit w_turn[5]  = '{0, 0, 0, 1, 0};
        do_reset();
        ib.mode = MODE_UP_WRAP; ib.tick = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks += 2;
            if (ib.counter !== up_cnt[i]) begin errors++; $display("FAIL upwrap_cnt[%0d] got=%0d exp=%0d", i, ib.counter, up_cnt[i]); end
            if (ib.turn !== w_turn[i])    begin errors++; $display("FAIL upwrap_turn[%0d] got=%0b exp=%0b", i, ib.turn, w_turn[i]); end
        end
        ib.tick = 0; ib.load = 1; ib.load_val = 3'd5;
        cyc();
        ib.load = 0;
        checks += 2;
        if (ib.counter !== 3'd5) begin errors++; $display("FAIL load5_cnt got=%0d exp=5", ib.counter); end
        if (ib.dir !== 1'b0)     begin errors++; $display("FAIL load5_dir got=%0b exp=0", ib.dir); end
        ib.mode = MODE_DOWN_WRAP; ib.tick = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks += 2;
            if (ib.counter !== dn_cnt[i]) begin errors++; $display("FAIL dnwrap_cnt[%0d] got=%0d exp=%0d", i, ib.counter, dn_cnt[i]); end
            if (ib.turn !== w_turn[i])    begin errors++; $display("FAIL dnwrap_turn[%0d] got=%0b exp=%0b", i, ib.turn, w_turn[i]); end
        end
        ib.tick = 0; ib.load = 1; ib.load_val = 3'd0;
        cyc();
        checks += 3;
        if (ib.counter !== 3'd2) begin errors++; $display("FAIL clamp_lo_cnt got=%0d exp=2", ib.counter); end
        if (ib.dir !== 1'b1)     begin errors++; $display("FAIL clamp_lo_dir got=%0b exp=1", ib.dir); end
        if (ib.at_lo !== 1'b1)   begin errors++; $display("FAIL clamp_lo_at_lo got=%0b exp=1", ib.at_lo); end
        ib.load_val = 3'd7;
        cyc();
        ib.load = 0;
        checks += 2;
        if (ib.counter !== 3'd5) begin errors++; $display("FAIL clamp_hi_cnt got=%0d exp=5", ib.counter); end
        if (ib.at_hi !== 1'b1)   begin errors++; $display("FAIL clamp_hi_at_hi got=%0b exp=1", ib.at_hi); end
    endtask

    task automatic test_oneshot();
        int ec;
        bit ed;
        do_reset();
        ia.mode = MODE_ONESHOT; ia.tick = 1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            ec = (i < 7) ? i + 1 : 7;
            ed = (i >= 6);
            checks += 3;
            if (ia.counter !== ec) begin errors++; $display("FAIL oneshot_cnt[%0d] got=%0d exp=%0d", i, ia.counter, ec); end
            if (ia.done !== ed)    begin errors++; $display("FAIL oneshot_done[%0d] got=%0b exp=%0b", i, ia.done, ed); end
            if (ia.turn !== 1'b0)  begin errors++; $display("FAIL oneshot_turn[%0d] got=%0b exp=0", i, ia.turn); end
        end
        ia.load = 1; ia.load_val = 4'd3;
        cyc();
        checks += 2;
        if (ia.counter !== 4'd3) begin errors++; $display("FAIL oneshot_load_cnt got=%0d exp=3", ia.counter); end
        if (ia.done !== 1'b0)    begin errors++; $display("FAIL oneshot_load_done got=%0b exp=0", ia.done); end
        ia.tick = 0; ia.load_val = 4'd7;
        cyc();
        ia.load = 0; ia.tick = 1;
        cyc();
        checks += 2;
        if (ia.counter !== 4'd7) begin errors++; $display("FAIL oneshot_at_hi_cnt got=%0d exp=7", ia.counter); end
        if (ia.done !== 1'b1)    begin errors++; $display("FAIL oneshot_at_hi_done got=%0b exp=1", ia.done); end
        ia.mode = MODE_UP_WRAP;
        cyc();
        ia.tick = 0;
        checks += 3;
        if (ia.counter !== 4'd0) begin errors++; $display("FAIL leave_oneshot_cnt got=%0d exp=0", ia.counter); end
        if (ia.done !== 1'b0)    begin errors++; $display("FAIL leave_oneshot_done got=%0b exp=0", ia.done); end
        if (ia.turn !== 1'b1)    begin errors++; $display("FAIL leave_oneshot_turn got=%0b exp=1", ia.turn); end
    endtask

    task automatic test_stop_load();
        do_reset();
        ia.mode = MODE_BOUNCE; ia.tick = 1;
        repeat (4) cyc();
        checks++;
        if (ia.counter !== 4'd4) begin errors++; $display("FAIL pre_stop_cnt got=%0d exp=4", ia.counter); end
        ia.stop = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks += 2;
            if (ia.counter !== 4'd4) begin errors++; $display("FAIL stop_cnt[%0d] got=%0d exp=4", i, ia.counter); end
            if (ia.turn !== 1'b0)    begin errors++; $display("FAIL stop_turn[%0d] got=%0b exp=0", i, ia.turn); end
        end
        ia.stop = 0;
        cyc();
        checks++;
        if (ia.counter !== 4'd5) begin errors++; $display("FAIL release_cnt got=%0d exp=5", ia.counter); end
        ia.tick = 0; ia.load = 1; ia.stop = 1; ia.load_val = 4'd9;
        cyc();
        ia.load = 0; ia.stop = 0;
        checks += 3;
        if (ia.counter !== 4'd7) begin errors++; $display("FAIL load_stop_cnt got=%0d exp=7", ia.counter); end
        if (ia.dir !== 1'b0)     begin errors++; $display("FAIL load_stop_dir got=%0b exp=0", ia.dir); end
        if (ia.at_hi !== 1'b1)   begin errors++; $display("FAIL load_stop_at_hi got=%0b exp=1", ia.at_hi); end
        ia.tick = 1;
        cyc();
        ia.tick = 0;
        checks += 2;
        if (ia.counter !== 4'd6) begin errors++; $display("FAIL down_from_hi_cnt got=%0d exp=6", ia.counter); end
        if (ia.turn !== 1'b0)    begin errors++; $display("FAIL down_from_hi_turn got=%0b exp=0", ia.turn); end
    endtask

    task automatic test_clr();
        do_reset();
        ia.mode = MODE_UP_WRAP; ia.tick = 1;
        repeat (5) cyc();
        checks++;
        if (ia.counter !== 4'd5) begin errors++; $display("FAIL pre_clr_cnt got=%0d exp=5", ia.counter); end
        ia.load = 1; ia.load_val = 4'd6; clr = 1;
        cyc();
        clr = 0; ia.load = 0; ia.tick = 0;
        checks += 4;
        if (ia.counter !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", ia.counter); end
        if (ia.dir !== 1'b1)     begin errors++; $display("FAIL clr_dir got=%0b exp=1", ia.dir); end
        if (ia.done !== 1'b0)    begin errors++; $display("FAIL clr_done got=%0b exp=0", ia.done); end
        if (ia.turn !== 1'b0)    begin errors++; $display("FAIL clr_turn got=%0b exp=0", ia.turn); end
    endtask

    task automatic test_dwell();
`ifdef COUNTER_DWELL_EN
        int ec[11] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
        bit et[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        int ec[11] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
        bit et[11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
`endif
        do_reset();
        ic.mode = MODE_BOUNCE; ic.tick = 1;
        for (int i = 0; i < 11; i++) begin
            cyc();
            checks += 2;
            if (ic.counter !== ec[i]) begin errors++; $display("FAIL dwell_cnt[%0d] got=%0d exp=%0d", i, ic.counter, ec[i]); end
            if (ic.turn !== et[i])    begin errors++; $display("FAIL dwell_turn[%0d] got=%0b exp=%0b", i, ic.turn, et[i]); end
        end
        ic.tick = 0;
    endtask

    task automatic test_tick_div();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (div_tick === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 4) begin errors++; $display("FAIL tick_div_pulses got=%0d exp=4", pulses); end
    endtask

    task automatic test_random();
        mdl_t m[3];
        int   lo[3]   = '{0, 2, 0};
        int   hi[3]   = '{7, 5, 3};
        int   vmax[3] = '{15, 7, 3};
        int   md[3]   = '{2, 0, 2};
        bit   tk[3], sp[3], ld[3];
        int   lv[3];
        int   oc[3];
        bit   od[3], ot[3], on[3], ol[3], oh[3];
        bit   rc;
        for (int i = 0; i < 3; i++) m[i] = '{cnt: 0, dir: 1, turn: 0, done: 0, spent: 0, lmode: 0};
        for (int c = 0; c < 600; c++) begin
            rc = (c == 0) || ($urandom_range(0, 99) < 2);
            for (int i = 0; i < 3; i++) begin
                tk[i] = ($urandom_range(0, 99) < 75);
                sp[i] = ($urandom_range(0, 99) < 12);
                ld[i] = ($urandom_range(0, 99) < 6);
                lv[i] = $urandom_range(0, vmax[i]);
                if ($urandom_range(0, 99) < 5) md[i] = $urandom_range(0, 3);
            end
            ia.tick = tk[0]; ia.stop = sp[0]; ia.load = ld[0]; ia.load_val = 4'(lv[0]); ia.mode = mode_t'(md[0]);
            ib.tick = tk[1]; ib.stop = sp[1]; ib.load = ld[1]; ib.load_val = 3'(lv[1]); ib.mode = mode_t'(md[1]);
            ic.tick = tk[2]; ic.stop = sp[2]; ic.load = ld[2]; ic.load_val = 2'(lv[2]); ic.mode = mode_t'(md[2]);
            clr = rc;
            cyc();
            clr = 0;
            for (int i = 0; i < 3; i++) m[i] = mstep(m[i], lo[i], hi[i], 2, rc, tk[i], sp[i], ld[i], lv[i], md[i]);
            oc = '{int'(ia.counter), int'(ib.counter), int'(ic.counter)};
            od = '{ia.dir, ib.dir, ic.dir};
            ot = '{ia.turn, ib.turn, ic.turn};
            on = '{ia.done, ib.done, ic.done};
            ol = '{ia.at_lo, ib.at_lo, ic.at_lo};
            oh = '{ia.at_hi, ib.at_hi, ic.at_hi};
            for (int i = 0; i < 3; i++) begin
                checks += 6;
                if (oc[i] !== m[i].cnt) begin errors++; $display("FAIL rnd_cnt u%0d cyc%0d got=%0d exp=%0d", i, c, oc[i], m[i].cnt); end
                if (od[i] !== m[i].dir) begin errors++; $display("FAIL rnd_dir u%0d cyc%0d got=%0b exp=%0b", i, c, od[i], m[i].dir); end
                if (ot[i] !== m[i].turn) begin errors++; $display("FAIL rnd_turn u%0d cyc%0d got=%0b exp=%0b", i, c, ot[i], m[i].turn); end
                if (on[i] !== m[i].done) begin errors++; $display("FAIL rnd_done u%0d cyc%0d got=%0b exp=%0b", i, c, on[i], m[i].done); end
                if (ol[i] !== (m[i].cnt == lo[i])) begin errors++; $display("FAIL rnd_at_lo u%0d cyc%0d got=%0b exp=%0b", i, c, ol[i], m[i].cnt == lo[i]); end
                if (oh[i] !== (m[i].cnt == hi[i])) begin errors++; $display("FAIL rnd_at_hi u%0d cyc%0d got=%0b exp=%0b", i, c, oh[i], m[i].cnt == hi[i]); end
            end
        end
        idle_all();
    endtask

    initial begin
        clr = 1'b0;
        idle_all();
        test_reset();
        test_bounce();
        test_wrap();
        test_oneshot();
        test_stop_load();
        test_clr();
        test_dwell();
        test_tick_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
